// File: rtl/inst_hw_prefetch_pkg.sv
// Shared types and widths for the Thumb halfword prefetcher.
// A buffered entry pairs a fetched word with its word address.
package inst_hw_prefetch_pkg;

  localparam int HW_W = 16;
  localparam int WORD_W = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [29:0]       waddr;
  } pf_word_t;

  function automatic logic [HW_W-1:0] hw_pick(
    input logic [WORD_W-1:0] w,
    input logic              sel
  );
    return sel ? w[31:16] : w[15:0];
  endfunction

endpackage

// File: rtl/inst_hw_prefetch_if.sv
// Memory read port, redirect input and halfword stream to the core.
// The master side is the prefetcher.
interface inst_hw_prefetch_if;
  import inst_hw_prefetch_pkg::*;

  logic              mem_req;
  logic [WORD_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [WORD_W-1:0] mem_rdata;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [HW_W-1:0]   inst_hw;
  logic              hw_valid;
  logic              hw_ready;
  logic [31:0]       hw_addr;

  modport master (
    output mem_req, mem_addr,
    input  mem_rvalid, mem_rdata,
    input  redirect, redirect_pc,
    output inst_hw, hw_valid, hw_addr,
    input  hw_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_rvalid, mem_rdata,
    output redirect, redirect_pc,
    input  inst_hw, hw_valid, hw_addr,
    output hw_ready
  );

endinterface

// File: rtl/inst_hw_prefetch_fifo.sv
// Word buffer for the prefetcher: DEPTH entries of data plus word address.
// Flush clears the pointers synchronously and beats a same-cycle push.
module pf_word_fifo
  import inst_hw_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  pf_word_t               wdata,
  input  logic                   pop,
  output pf_word_t               head,
  output logic [$clog2(DEPTH):0] cnt,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pf_word_t       store [DEPTH];
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;
  logic           push_ok;
  logic           pop_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = store[rp];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) store[wp] <= wdata;
  end

endmodule

// File: rtl/inst_hw_prefetch.sv
// Instruction prefetcher: word reads from memory, Thumb halfwords out
// in program order, flush and restart on redirect.
module inst_hw_prefetch
  import inst_hw_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  inst_hw_prefetch_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW:0]   inflight;
  logic [31:0]   fetch_addr;
  logic [29:0]   ret_waddr;
  logic          hsel;
  logic          skip_lo;
  logic          issue;
  logic          push;
  logic          pop;
  logic          xfer;
  logic          empty;
  logic          full;
  pf_word_t      head;
  pf_word_t      wword;

  assign inflight = {1'b0, fifo_cnt} + {1'b0, outstanding};
  assign issue    = !rst && !bus.redirect && (inflight < DEPTH_W);
  assign xfer     = bus.hw_valid && bus.hw_ready;
  assign push     = bus.mem_rvalid && !bus.redirect && (drop_cnt == '0);
  assign pop      = xfer && hsel;

  assign wword.data  = bus.mem_rdata;
  assign wword.waddr = ret_waddr;

  assign bus.mem_req  = issue;
  assign bus.mem_addr = fetch_addr;
  assign bus.hw_valid = !empty;
  assign bus.inst_hw  = empty ? '0 : hw_pick(head.data, hsel);
  assign bus.hw_addr  = empty ? '0 : {head.waddr, hsel, 1'b0};

  pf_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect),
    .push  (push),
    .wdata (wword),
    .pop   (pop),
    .head  (head),
    .cnt   (fifo_cnt),
    .empty (empty),
    .full  (full)
  );

  // Returns are in order and all dropped words precede the new stream,
  // so a single counter tracks the address of the next kept word.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr  <= RESET_PC & 32'hFFFF_FFFC;
      ret_waddr   <= RESET_PC[31:2];
      skip_lo     <= RESET_PC[1];
      hsel        <= 1'b0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue)
                     - CW'(bus.mem_rvalid);
      if (bus.redirect) begin
        fetch_addr <= bus.redirect_pc & 32'hFFFF_FFFC;
        ret_waddr  <= bus.redirect_pc[31:2];
        skip_lo    <= bus.redirect_pc[1];
        hsel       <= 1'b0;
        drop_cnt   <= outstanding - CW'(bus.mem_rvalid);
      end else begin
        if (issue) fetch_addr <= fetch_addr + 32'd4;
        if (bus.mem_rvalid && drop_cnt != '0)
          drop_cnt <= drop_cnt - 1'b1;
        if (push) ret_waddr <= ret_waddr + 30'd1;
        if (push && empty) begin
          hsel    <= skip_lo;
          skip_lo <= 1'b0;
        end else if (xfer) begin
          hsel <= ~hsel;
        end
      end
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst) inflight <= DEPTH_W);
  a_no_push_full: assert property (
    @(posedge clk) disable iff (rst) !(push && full && !pop));
  a_no_pop_empty: assert property (
    @(posedge clk) disable iff (rst) !(pop && empty));
  a_out_underflow: assert property (
    @(posedge clk) disable iff (rst)
    !(bus.mem_rvalid && outstanding == '0));
  a_drop_bound: assert property (
    @(posedge clk) disable iff (rst) drop_cnt <= outstanding);

endmodule

// File: tb/tb_inst_hw_prefetch.sv
// Directed bench for inst_hw_prefetch with a variable-latency memory
// whose word at A is {A[15:0]+2, A[15:0]}, so inst_hw tracks hw_addr.
module tb_inst_hw_prefetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total = 0;
  int   lat = 1;

  always #5 clk = ~clk;

  inst_hw_prefetch_if bus ();

  inst_hw_prefetch #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  pv;
  logic [31:0] pa [8];
  logic [31:0] ra;
  logic [31:0] req_q [$];

  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[6:0], bus.mem_req};
      pa[0] <= bus.mem_addr;
      for (int k = 1; k < 8; k++) pa[k] <= pa[k-1];
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.mem_req) req_q.push_back(bus.mem_addr);
  end

  assign bus.mem_rvalid = pv[lat-1];
  assign ra = pa[lat-1];
  assign bus.mem_rdata = {ra[15:0] + 16'h2, ra[15:0]};

  task automatic test_reset();
    rst = 1'b1;
    lat = 1;
    bus.hw_ready = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.mem_req !== 1'b0)
      $display("FAIL reset_mem_req: got %b want 0", bus.mem_req);
    else passed++;
    total++;
    if (bus.hw_valid !== 1'b0)
      $display("FAIL reset_hw_valid: got %b want 0", bus.hw_valid);
    else passed++;
    total++;
    if (bus.inst_hw !== 16'h0)
      $display("FAIL reset_inst_hw: got %h want 0000", bus.inst_hw);
    else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    int n;
    req_q.delete();
    rst = 1'b0;
    n = 0;
    while (!bus.hw_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.hw_valid !== 1'b1)
      $display("FAIL stream_start: got hw_valid=%b want 1", bus.hw_valid);
    else passed++;
    total++;
    if (req_q.size() == 0 || req_q[0] !== 32'h0)
      $display("FAIL stream_first_req: got size %0d want addr 0",
               req_q.size());
    else passed++;
    exp = 32'h0;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (bus.hw_valid !== 1'b1 || bus.hw_addr !== exp ||
          bus.inst_hw !== exp[15:0])
        $display("FAIL stream_hw%0d: got v=%b a=%h d=%h want a=%h d=%h",
                 i, bus.hw_valid, bus.hw_addr, bus.inst_hw,
                 exp, exp[15:0]);
      else passed++;
      exp += 32'd2;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    rst = 1'b1;
    bus.hw_ready = 1'b0;
    repeat (2) @(negedge clk);
    req_q.delete();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (req_q.size() != 4)
      $display("FAIL bp_req_count: got %0d want 4", req_q.size());
    else passed++;
    for (int i = 0; i < req_q.size() && i < 4; i++) begin
      total++;
      if (req_q[i] !== 32'(i * 4))
        $display("FAIL bp_req_addr%0d: got %h want %h",
                 i, req_q[i], 32'(i * 4));
      else passed++;
    end
    total++;
    if (bus.mem_req !== 1'b0)
      $display("FAIL bp_req_idle: got %b want 0", bus.mem_req);
    else passed++;
    bus.hw_ready = 1'b1;
    exp = 32'h0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (bus.hw_valid !== 1'b1 || bus.hw_addr !== exp ||
          bus.inst_hw !== exp[15:0])
        $display("FAIL bp_drain%0d: got v=%b a=%h d=%h want a=%h",
                 i, bus.hw_valid, bus.hw_addr, bus.inst_hw, exp);
      else passed++;
      exp += 32'd2;
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_drop();
    int n;
    rst = 1'b1;
    lat = 3;
    bus.hw_ready = 1'b1;
    repeat (2) @(negedge clk);
    req_q.delete();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (req_q.size() != 2 || bus.mem_rvalid !== 1'b0)
      $display("FAIL rd_pending: got reqs=%0d rvalid=%b want 2,0",
               req_q.size(), bus.mem_rvalid);
    else passed++;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0102;
    #1;
    total++;
    if (bus.mem_req !== 1'b0)
      $display("FAIL rd_req_blocked: got %b want 0", bus.mem_req);
    else passed++;
    req_q.delete();
    @(negedge clk);
    bus.redirect = 1'b0;
    n = 0;
    while (!bus.hw_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.hw_valid !== 1'b1 || bus.hw_addr !== 32'h102 ||
        bus.inst_hw !== 16'h0102)
      $display("FAIL rd_first: got v=%b a=%h d=%h want a=102 d=0102",
               bus.hw_valid, bus.hw_addr, bus.inst_hw);
    else passed++;
    total++;
    if (req_q.size() == 0 || req_q[0] !== 32'h100)
      $display("FAIL rd_new_req: got size %0d want first addr 100",
               req_q.size());
    else passed++;
    @(negedge clk);
    total++;
    if (bus.hw_valid !== 1'b1 || bus.hw_addr !== 32'h104 ||
        bus.inst_hw !== 16'h0104)
      $display("FAIL rd_second: got v=%b a=%h d=%h want a=104 d=0104",
               bus.hw_valid, bus.hw_addr, bus.inst_hw);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.hw_valid !== 1'b1 || bus.hw_addr !== 32'h106)
      $display("FAIL rd_third: got v=%b a=%h want a=106",
               bus.hw_valid, bus.hw_addr);
    else passed++;
  endtask

  task automatic test_redirect_coincident();
    int n;
    logic hit;
    rst = 1'b1;
    lat = 1;
    bus.hw_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n = 0;
    hit = bus.hw_valid && bus.mem_rvalid;
    while (!hit && n < 10) begin
      @(negedge clk);
      n++;
      hit = bus.hw_valid && bus.mem_rvalid;
    end
    total++;
    if (hit !== 1'b1)
      $display("FAIL rc_window: got %b want 1", hit);
    else passed++;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    @(negedge clk);
    bus.redirect = 1'b0;
    total++;
    if (bus.hw_valid !== 1'b0)
      $display("FAIL rc_flushed: got %b want 0", bus.hw_valid);
    else passed++;
    n = 0;
    while (!bus.hw_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.hw_valid !== 1'b1 || bus.hw_addr !== 32'h200 ||
        bus.inst_hw !== 16'h0200)
      $display("FAIL rc_first: got v=%b a=%h d=%h want a=200 d=0200",
               bus.hw_valid, bus.hw_addr, bus.inst_hw);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.hw_valid !== 1'b1 || bus.hw_addr !== 32'h202)
      $display("FAIL rc_second: got v=%b a=%h want a=202",
               bus.hw_valid, bus.hw_addr);
    else passed++;
  endtask

  task automatic test_wrap();
    int n;
    logic [31:0] exp_a [4];
    exp_a[0] = 32'hFFFF_FFFC;
    exp_a[1] = 32'hFFFF_FFFE;
    exp_a[2] = 32'h0000_0000;
    exp_a[3] = 32'h0000_0002;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    req_q.delete();
    @(negedge clk);
    bus.redirect = 1'b0;
    n = 0;
    while (!bus.hw_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.hw_valid !== 1'b1 || bus.hw_addr !== exp_a[i] ||
          bus.inst_hw !== exp_a[i][15:0])
        $display("FAIL wrap_hw%0d: got v=%b a=%h d=%h want a=%h",
                 i, bus.hw_valid, bus.hw_addr, bus.inst_hw, exp_a[i]);
      else passed++;
      @(negedge clk);
    end
    total++;
    if (req_q.size() < 2 || req_q[0] !== 32'hFFFF_FFFC ||
        req_q[1] !== 32'h0)
      $display("FAIL wrap_reqs: got size %0d want FFFFFFFC,00000000",
               req_q.size());
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    bus.hw_ready = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (bus.hw_valid !== 1'b1)
      $display("FAIL rm_full: got hw_valid=%b want 1", bus.hw_valid);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.hw_valid !== 1'b0 || bus.mem_req !== 1'b0 ||
        bus.inst_hw !== 16'h0)
      $display("FAIL rm_cleared: got v=%b req=%b d=%h want 0,0,0000",
               bus.hw_valid, bus.mem_req, bus.inst_hw);
    else passed++;
    req_q.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.hw_ready = 1'b1;
    n = 0;
    while (!bus.hw_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (req_q.size() == 0 || req_q[0] !== 32'h0)
      $display("FAIL rm_first_req: got size %0d want first addr 0",
               req_q.size());
    else passed++;
    total++;
    if (bus.hw_valid !== 1'b1 || bus.hw_addr !== 32'h0)
      $display("FAIL rm_first_hw: got v=%b a=%h want a=0",
               bus.hw_valid, bus.hw_addr);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_coincident();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
